datapath_stream_aligner: RTL and testbench

Parametrised multi-stream alignment pipeline for the DSP datapath. Runtime-configurable per-stream delays replace fixed elaboration-time pipeline depths for the ADC-code, error, sliced-bit and detector-flag streams. Adds input-valid stalling, a runtime bit aligner, a priming/valid indicator and config-change re-priming. Sits between the channel-filter/error stage and the sliding detector and output debug taps.

---
 rtl/dsp_align_pkg.sv | 29 ++
 rtl/stall_delay_line.sv | 41 ++++
 rtl/datapath_stream_aligner.sv | 123 ++++++++++++
 tb/tb_datapath_stream_aligner.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_align_pkg.sv
// Shared types and helpers for the DSP multi-stream alignment pipeline.
package dsp_align_pkg;

  localparam int NUM_CHANNELS_DEFAULT = 16;
  localparam int CODE_WIDTH_DEFAULT   = 8;
  localparam int ERR_WIDTH_DEFAULT    = 9;
  localparam int FLAG_WIDTH_DEFAULT   = 2;
  localparam int MAX_DELAY_DEFAULT    = 8;

  // Lane-packed words at default geometry; lane i sits at [i].
  typedef logic [NUM_CHANNELS_DEFAULT-1:0][CODE_WIDTH_DEFAULT-1:0] code_word_t;
  typedef logic [NUM_CHANNELS_DEFAULT-1:0][ERR_WIDTH_DEFAULT-1:0]  err_word_t;
  typedef logic [NUM_CHANNELS_DEFAULT-1:0][FLAG_WIDTH_DEFAULT-1:0] flag_word_t;

  // Beats needed before every stream shows real data; the bit stream
  // carries one extra beat from the aligner's previous-word register.
  function automatic int unsigned fill_target(input int unsigned d_code,
                                              input int unsigned d_err,
                                              input int unsigned d_bit,
                                              input int unsigned d_flag);
    int unsigned m;
    m = d_code;
    if (d_err > m) m = d_err;
    if (d_bit + 1 > m) m = d_bit + 1;
    if (d_flag > m) m = d_flag;
    return m + 1;
  endfunction

endpackage

// File: rtl/stall_delay_line.sv
// Enable-gated tap line for one lane-packed stream with runtime tap select
// and a registered output. Requires maxDelay >= 1.
module stall_delay_line #(
  parameter int bitwidth    = 8,
  parameter int numChannels = 16,
  parameter int maxDelay    = 8
) (
  input  logic                                  clk,
  input  logic                                  rstb,
  input  logic                                  en,
  input  logic [$clog2(maxDelay+1)-1:0]         sel,
  input  logic [bitwidth*numChannels-1:0]       din,
  output logic [bitwidth*numChannels-1:0]       dout
);

  localparam int W     = bitwidth * numChannels;
  localparam int SEL_W = $clog2(maxDelay + 1);

  logic [W-1:0] hist [1:maxDelay];
  logic [W-1:0] tap_sel;

  // Tap 0 is the live input; tap k is the word from k beats earlier.
  always_comb begin
    tap_sel = din;
    for (int unsigned k = 1; k <= maxDelay; k++) begin
      if (sel == SEL_W'(k)) tap_sel = hist[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      for (int unsigned k = 1; k <= maxDelay; k++) hist[k] <= '0;
      dout <= '0;
    end else if (en) begin
      hist[1] <= din;
      for (int unsigned k = 2; k <= maxDelay; k++) hist[k] <= hist[k-1];
      dout <= tap_sel;
    end
  end

endmodule

// File: rtl/datapath_stream_aligner.sv
// Multi-stream alignment pipeline: per-stream runtime delays, bit aligner,
// stall handling, priming indicator and sticky config-range error.
module datapath_stream_aligner
  import dsp_align_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEFAULT,
  parameter int CODE_WIDTH   = CODE_WIDTH_DEFAULT,
  parameter int ERR_WIDTH    = ERR_WIDTH_DEFAULT,
  parameter int FLAG_WIDTH   = FLAG_WIDTH_DEFAULT,
  parameter int MAX_DELAY    = MAX_DELAY_DEFAULT,
  parameter int DELAY_WIDTH  = 4
) (
  input  logic                               clk,
  input  logic                               rstb,
  input  logic                               in_valid,
  input  logic [NUM_CHANNELS*CODE_WIDTH-1:0] codes_in,
  input  logic [NUM_CHANNELS*ERR_WIDTH-1:0]  errs_in,
  input  logic [NUM_CHANNELS-1:0]            bits_in,
  input  logic [NUM_CHANNELS*FLAG_WIDTH-1:0] flags_in,
  input  logic [DELAY_WIDTH-1:0]             code_delay,
  input  logic [DELAY_WIDTH-1:0]             err_delay,
  input  logic [DELAY_WIDTH-1:0]             bit_delay,
  input  logic [DELAY_WIDTH-1:0]             flag_delay,
  input  logic [$clog2(NUM_CHANNELS)-1:0]    align_pos,
  output logic [NUM_CHANNELS*CODE_WIDTH-1:0] codes_out,
  output logic [NUM_CHANNELS*ERR_WIDTH-1:0]  errs_out,
  output logic [NUM_CHANNELS-1:0]            bits_out,
  output logic [NUM_CHANNELS*FLAG_WIDTH-1:0] flags_out,
  output logic                               out_valid,
  output logic                               cfg_error
);

  localparam int AW    = $clog2(NUM_CHANNELS);
  localparam int SEL_W = $clog2(MAX_DELAY + 1);
  localparam int CNT_W = $clog2(MAX_DELAY + 3);
  localparam int CFG_W = 4 * DELAY_WIDTH + AW;

  function automatic logic [SEL_W-1:0] clamp(input logic [DELAY_WIDTH-1:0] cfg);
    if (int'(cfg) > MAX_DELAY) return SEL_W'(MAX_DELAY);
    return SEL_W'(cfg);
  endfunction

  logic [SEL_W-1:0] d_code, d_err, d_bit, d_flag;
  logic             cfg_over;

  always_comb begin
    d_code   = clamp(code_delay);
    d_err    = clamp(err_delay);
    d_bit    = clamp(bit_delay);
    d_flag   = clamp(flag_delay);
    cfg_over = (int'(code_delay) > MAX_DELAY) || (int'(err_delay) > MAX_DELAY) ||
               (int'(bit_delay)  > MAX_DELAY) || (int'(flag_delay) > MAX_DELAY);
  end

  // Bit aligner: window of N bits starting at align_pos over {current, previous}.
  logic [NUM_CHANNELS-1:0]   prev_word, aligned;
  logic [2*NUM_CHANNELS-1:0] concat;

  always_comb begin
    concat  = {bits_in, prev_word};
    aligned = concat[align_pos +: NUM_CHANNELS];
  end

  always_ff @(posedge clk) begin
    if (!rstb)         prev_word <= '0;
    else if (in_valid) prev_word <= bits_in;
  end

  // Config copy loads even in reset so a config held steady across reset
  // does not count as a change on the first cycle out of reset.
  logic [CFG_W-1:0] cfg_now, cfg_q;
  logic             cfg_changed;

  assign cfg_now     = {code_delay, err_delay, bit_delay, flag_delay, align_pos};
  assign cfg_changed = (cfg_now != cfg_q);

  always_ff @(posedge clk) begin
    cfg_q <= cfg_now;
  end

  logic [CNT_W-1:0] target, fill_cnt, fill_inc;

  always_comb begin
    target   = CNT_W'(fill_target(32'(d_code), 32'(d_err), 32'(d_bit), 32'(d_flag)));
    fill_inc = (fill_cnt >= target) ? target : fill_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      if (cfg_over) cfg_error <= 1'b1;
      if (cfg_changed) begin
        fill_cnt  <= '0;
        out_valid <= 1'b0;
      end else if (in_valid) begin
        fill_cnt  <= fill_inc;
        out_valid <= (fill_inc == target);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  stall_delay_line #(.bitwidth(CODE_WIDTH), .numChannels(NUM_CHANNELS), .maxDelay(MAX_DELAY))
    u_code_line (.clk(clk), .rstb(rstb), .en(in_valid), .sel(d_code),
                 .din(codes_in), .dout(codes_out));

  stall_delay_line #(.bitwidth(ERR_WIDTH), .numChannels(NUM_CHANNELS), .maxDelay(MAX_DELAY))
    u_err_line (.clk(clk), .rstb(rstb), .en(in_valid), .sel(d_err),
                .din(errs_in), .dout(errs_out));

  stall_delay_line #(.bitwidth(1), .numChannels(NUM_CHANNELS), .maxDelay(MAX_DELAY))
    u_bit_line (.clk(clk), .rstb(rstb), .en(in_valid), .sel(d_bit),
                .din(aligned), .dout(bits_out));

  stall_delay_line #(.bitwidth(FLAG_WIDTH), .numChannels(NUM_CHANNELS), .maxDelay(MAX_DELAY))
    u_flag_line (.clk(clk), .rstb(rstb), .en(in_valid), .sel(d_flag),
                 .din(flags_in), .dout(flags_out));

endmodule

// File: tb/tb_datapath_stream_aligner.sv
// Self-checking bench for datapath_stream_aligner: directed sequences, an
// aligner vector table and randomized traffic against a queue-based model.
module tb_datapath_stream_aligner;
  import dsp_align_pkg::*;

  localparam int N  = 16;
  localparam int CW = 8;
  localparam int EW = 9;
  localparam int FW = 2;
  localparam int MD = 8;
  localparam int DW = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstb, in_valid;
  code_word_t       codes_in, codes_out;
  err_word_t        errs_in, errs_out;
  flag_word_t       flags_in, flags_out;
  logic [N-1:0]     bits_in, bits_out;
  logic [DW-1:0]    code_delay, err_delay, bit_delay, flag_delay;
  logic [AW-1:0]    align_pos;
  logic             out_valid, cfg_error;

  datapath_stream_aligner #(
    .NUM_CHANNELS(N), .CODE_WIDTH(CW), .ERR_WIDTH(EW), .FLAG_WIDTH(FW),
    .MAX_DELAY(MD), .DELAY_WIDTH(DW)
  ) dut (
    .clk(clk), .rstb(rstb), .in_valid(in_valid),
    .codes_in(codes_in), .errs_in(errs_in), .bits_in(bits_in), .flags_in(flags_in),
    .code_delay(code_delay), .err_delay(err_delay), .bit_delay(bit_delay),
    .flag_delay(flag_delay), .align_pos(align_pos),
    .codes_out(codes_out), .errs_out(errs_out), .bits_out(bits_out),
    .flags_out(flags_out), .out_valid(out_valid), .cfg_error(cfg_error)
  );

  int checks;
  int failures;

  // Reference model: history of accepted words, newest at the back.
  code_word_t   q_code[$];
  err_word_t    q_err[$];
  logic [N-1:0] q_bit[$];
  flag_word_t   q_flag[$];
  logic [N-1:0] m_prev;
  code_word_t   e_code;
  err_word_t    e_err;
  logic [N-1:0] e_bit;
  flag_word_t   e_flag;
  logic         e_valid, e_cfgerr;
  int           m_cnt;
  logic [4*DW+AW-1:0] m_cfg;

  function automatic int eff(input logic [DW-1:0] c);
    return (int'(c) > MD) ? MD : int'(c);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int dc, de, db, df, t, mx;
    logic changed;
    logic [2*N-1:0] cat;
    logic [N-1:0] al;
    logic [4*DW+AW-1:0] cur;
    cur = {code_delay, err_delay, bit_delay, flag_delay, align_pos};
    if (!rstb) begin
      q_code.delete(); q_err.delete(); q_bit.delete(); q_flag.delete();
      m_prev = '0; e_code = '0; e_err = '0; e_bit = '0; e_flag = '0;
      e_valid = 1'b0; e_cfgerr = 1'b0; m_cnt = 0;
    end else begin
      dc = eff(code_delay); de = eff(err_delay); db = eff(bit_delay); df = eff(flag_delay);
      if (int'(code_delay) > MD || int'(err_delay) > MD ||
          int'(bit_delay) > MD || int'(flag_delay) > MD) e_cfgerr = 1'b1;
      changed = (cur != m_cfg);
      if (in_valid) begin
        cat = {bits_in, m_prev};
        al = N'(cat >> align_pos);
        m_prev = bits_in;
        q_code.push_back(codes_in); q_err.push_back(errs_in);
        q_bit.push_back(al);        q_flag.push_back(flags_in);
        if (q_code.size() > MD + 1) begin
          void'(q_code.pop_front()); void'(q_err.pop_front());
          void'(q_bit.pop_front());  void'(q_flag.pop_front());
        end
        e_code = (q_code.size() > dc) ? q_code[q_code.size()-1-dc] : '0;
        e_err  = (q_err.size()  > de) ? q_err[q_err.size()-1-de]   : '0;
        e_bit  = (q_bit.size()  > db) ? q_bit[q_bit.size()-1-db]   : '0;
        e_flag = (q_flag.size() > df) ? q_flag[q_flag.size()-1-df] : '0;
      end
      mx = dc;
      if (de > mx) mx = de;
      if (db + 1 > mx) mx = db + 1;
      if (df > mx) mx = df;
      t = mx + 1;
      if (changed) begin
        m_cnt = 0; e_valid = 1'b0;
      end else if (in_valid) begin
        m_cnt = (m_cnt + 1 > t) ? t : m_cnt + 1;
        e_valid = (m_cnt == t);
      end else begin
        e_valid = 1'b0;
      end
    end
    m_cfg = cur;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_codes", codes_out, e_code);
    chk("m_errs",  errs_out,  e_err);
    chk("m_bits",  bits_out,  e_bit);
    chk("m_flags", flags_out, e_flag);
    chk("m_valid", out_valid, e_valid);
    chk("m_cfgerr", cfg_error, e_cfgerr);
  endtask

  task automatic drive_ramp(input int k);
    for (int i = 0; i < N; i++) begin
      codes_in[i] = CW'(k);
      errs_in[i]  = EW'(k);
      flags_in[i] = FW'(k);
    end
    bits_in = N'($urandom);
  endtask

  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      codes_in[i] = CW'($urandom);
      errs_in[i]  = EW'($urandom);
      flags_in[i] = FW'($urandom);
    end
    bits_in = N'($urandom);
  endtask

  typedef struct {
    logic [AW-1:0] ap;
    logic [N-1:0]  bits;
    logic [N-1:0]  exp;
  } al_vec_t;

  al_vec_t tbl [8];

  initial begin
    checks = 0;
    failures = 0;
    tbl[0] = '{4'd5,  16'hFFFF, 16'hF800};
    tbl[1] = '{4'd5,  16'h0000, 16'h07FF};
    tbl[2] = '{4'd5,  16'hFFFF, 16'hF800};
    tbl[3] = '{4'd5,  16'h0000, 16'h07FF};
    tbl[4] = '{4'd0,  16'h1234, 16'h0000};
    tbl[5] = '{4'd0,  16'hABCD, 16'h1234};
    tbl[6] = '{4'd15, 16'h8001, 16'h0003};
    tbl[7] = '{4'd8,  16'h00FF, 16'hFF80};

    rstb = 1'b0; in_valid = 1'b0;
    codes_in = '0; errs_in = '0; bits_in = '0; flags_in = '0;
    code_delay = 4'd0; err_delay = 4'd2; bit_delay = 4'd3; flag_delay = 4'd1;
    align_pos = '0;
    repeat (2) cycle();
    chk("reset_codes", codes_out, '0);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_cfgerr", cfg_error, 1'b0);

    // Ramp: codes at delay 0, errs lag 2 beats, valid on beat 5.
    rstb = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      drive_ramp(k);
      cycle();
      chk("ramp_code", codes_out[0], CW'(k));
      chk("ramp_err", errs_out[3], EW'((k > 2) ? k - 2 : 0));
      chk("ramp_valid", out_valid, (k >= 5));
    end

    // Stall for 3 cycles: outputs hold, valid low.
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      drive_random();
      cycle();
      chk("stall_code", codes_out[0], CW'(6));
      chk("stall_valid", out_valid, 1'b0);
    end
    in_valid = 1'b1;
    for (int k = 7; k <= 10; k++) begin
      drive_ramp(k);
      cycle();
      chk("resume_code", codes_out[5], CW'(k));
      chk("resume_err", errs_out[0], EW'(k - 2));
      chk("resume_valid", out_valid, 1'b1);
    end

    // Config changes: code_delay 0->2, then 2->4 mid-stream.
    code_delay = 4'd2;
    for (int k = 11; k <= 16; k++) begin
      drive_ramp(k);
      cycle();
      chk("cc2_valid", out_valid, (k == 16));
    end
    code_delay = 4'd4;
    for (int k = 17; k <= 22; k++) begin
      drive_ramp(k);
      cycle();
      chk("cc4_code", codes_out[0], CW'(k - 4));
      chk("cc4_valid", out_valid, (k == 22));
      chk("cc4_cfgerr", cfg_error, 1'b0);
    end

    // Clamp: 12 behaves as 8 and latches cfg_error.
    code_delay = 4'd12;
    for (int k = 23; k <= 30; k++) begin
      drive_ramp(k);
      cycle();
      chk("clamp_code", codes_out[0], CW'(k - 8));
      chk("clamp_cfgerr", cfg_error, 1'b1);
    end
    code_delay = 4'd3;
    for (int k = 31; k <= 33; k++) begin
      drive_ramp(k);
      cycle();
      chk("clamp3_code", codes_out[0], CW'(k - 3));
      chk("clamp3_cfgerr", cfg_error, 1'b1);
    end

    // Reset mid-stream with in_valid high.
    rstb = 1'b0;
    drive_ramp(34);
    cycle();
    chk("rst_codes", codes_out, '0);
    chk("rst_errs", errs_out, '0);
    chk("rst_bits", bits_out, '0);
    chk("rst_flags", flags_out, '0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_cfgerr", cfg_error, 1'b0);
    rstb = 1'b1;
    for (int b = 1; b <= 6; b++) begin
      drive_ramp(34 + b);
      cycle();
      chk("reprime_valid", out_valid, (b >= 5));
    end

    // Aligner vector table, all delays 0, starting from a cleared previous word.
    code_delay = '0; err_delay = '0; bit_delay = '0; flag_delay = '0;
    rstb = 1'b0;
    cycle();
    rstb = 1'b1;
    for (int r = 0; r < 8; r++) begin
      align_pos = tbl[r].ap;
      bits_in = tbl[r].bits;
      cycle();
      chk("align_tbl", bits_out, tbl[r].exp);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      drive_random();
      in_valid = ($urandom_range(0, 9) < 7);
      rstb = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 24) == 0) code_delay = DW'($urandom_range(0, 10));
      if ($urandom_range(0, 24) == 0) err_delay  = DW'($urandom_range(0, 9));
      if ($urandom_range(0, 24) == 0) bit_delay  = DW'($urandom_range(0, 9));
      if ($urandom_range(0, 24) == 0) flag_delay = DW'($urandom_range(0, 9));
      if ($urandom_range(0, 29) == 0) align_pos  = AW'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
